// File: rtl/multiply_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multiply_iter
// Brief    : Iterative signed/unsigned multiply (shift-add) and restoring
//            divide, one bit per cycle, start/busy/done handshake with flush
//            and divide-by-zero reporting. Results feed the HI/LO write path.
// Revision : 1.0  initial release
// ============================================================================
module multiply_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mult,
    input  logic             div,
    input  logic             unsign,
    input  logic             flush,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               is_mult_q, is_mult_d;
    logic               neg_res_q, neg_res_d;   // product / quotient negate
    logic               neg_rem_q, neg_rem_d;   // remainder follows dividend
    logic               dz_q, dz_d;             // divide with zero divisor
    logic [WIDTH-1:0]   d1_raw_q, d1_raw_d;     // dividend as presented
    logic [WIDTH-1:0]   mcand_q, mcand_d;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;           // mult accumulator; low half = quotient in div
    logic [WIDTH:0]     rem_q, rem_d;           // shifted partial remainder
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   out1_q, out1_d;
    logic [WIDTH-1:0]   out2_q, out2_d;

    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [WIDTH:0]     w_mult_sum;
    logic               w_ge;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_base;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem;

    // Operand magnitudes and per-iteration datapath
    always_comb begin
        w_mag1     = (!unsign && data1[WIDTH-1]) ? -data1 : data1;
        w_mag2     = (!unsign && data2[WIDTH-1]) ? -data2 : data2;
        w_mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        w_ge       = (rem_q >= {1'b0, mcand_q});
        w_sub      = rem_q - {1'b0, mcand_q};
        w_base     = w_ge ? w_sub : rem_q;
        w_prod     = neg_res_q ? -acc_q : acc_q;
        w_quo      = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        w_rem      = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    // Next-state, iteration and result-write logic
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_mult_d = is_mult_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        d1_raw_d  = d1_raw_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        out1_d    = out1_q;
        out2_d    = out2_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (mult || div) && !flush) begin
                    state_d   = S_CALC;
                    count_d   = C_CNT_INIT;
                    is_mult_d = mult;
                    neg_res_d = !unsign && (data1[WIDTH-1] ^ data2[WIDTH-1]);
                    neg_rem_d = !unsign && data1[WIDTH-1];
                    dz_d      = !mult && (data2 == '0);
                    d1_raw_d  = data1;
                    if (mult) begin
                        mcand_d = w_mag1;
                        acc_d   = {{WIDTH{1'b0}}, w_mag2};
                        rem_d   = '0;
                    end else begin
                        // First dividend bit enters the remainder now; the rest
                        // shift out of the accumulator low half MSB first.
                        mcand_d = w_mag2;
                        acc_d   = {{WIDTH{1'b0}}, w_mag1[WIDTH-2:0], 1'b0};
                        rem_d   = {{WIDTH{1'b0}}, w_mag1[WIDTH-1]};
                    end
                end
            end
            S_CALC: begin
                if (is_mult_q) begin
                    acc_d = {w_mult_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], w_ge};
                    // Keep the final remainder unshifted on the last step
                    rem_d = (count_q == '0) ? w_base : {w_base[WIDTH-1:0], acc_q[WIDTH-1]};
                end
                count_d = count_q - 1'b1;
                if (count_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_mult_q) begin
                    out1_d = w_prod[WIDTH-1:0];
                    out2_d = w_prod[2*WIDTH-1:WIDTH];
                end else if (dz_q) begin
                    out1_d = '1;
                    out2_d = d1_raw_q;
                    dbz_d  = 1'b1;
                end else begin
                    out1_d = w_quo;
                    out2_d = w_rem;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything except reset; results are left untouched
        if (flush) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
            out1_d  = out1_q;
            out2_d  = out2_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            is_mult_q <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            d1_raw_q  <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            out1_q    <= '0;
            out2_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_mult_q <= is_mult_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            d1_raw_q  <= d1_raw_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign out_data1   = out1_q;
    assign out_data2   = out2_q;

endmodule
`default_nettype wire
